// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUControl opcodes, arbiter FSM states and the
// legal-opcode check used by the arbiter to flag bad requests.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } arbState_e;

  function automatic logic isLegalOp(input logic [3:0] op);
    return (op == ALU_AND) || (op == ALU_OR) || (op == ALU_ADD) ||
           (op == ALU_SUB) || (op == ALU_PASSB);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational N-bit ALU; arithmetic wraps modulo 2^N and unknown codes give 0.
module alu
  import alu_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   ALUControl,
  output logic [N-1:0] result,
  output logic         zero
);

  always_comb begin
    result = '0;
    case (ALUControl)
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared ALU: round-robin grant on ties,
// one operation in flight, response held until the consumer takes it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [3:0]   req0_op,
  input  logic [3:0]   req1_op,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [N-1:0] resp_result,
  output logic         resp_zero,
  output logic         resp_err
);

  arbState_e   state_q;
  logic        lastGrant_q;
  logic [N-1:0] opA_q;
  logic [N-1:0] opB_q;
  logic [3:0]  opCode_q;
  logic        opId_q;
  logic        respValid_q;
  logic        respId_q;
  logic [N-1:0] respResult_q;
  logic        respZero_q;
  logic        respErr_q;

  logic        grant1;
  logic        handshake;
  logic        opLegal;
  logic [N-1:0] aluResult;
  logic        aluZero;

  // On a tie the requester that did not win last time is served.
  assign grant1     = req1_valid && (!req0_valid || !lastGrant_q);
  assign req0_ready = reset && (state_q == IDLE) && req0_valid && !grant1;
  assign req1_ready = reset && (state_q == IDLE) && grant1;
  assign handshake  = (req0_ready && req0_valid) || (req1_ready && req1_valid);
  assign opLegal    = isLegalOp(opCode_q);

  alu #(.N(N)) u_alu (
    .a          (opA_q),
    .b          (opB_q),
    .ALUControl (opCode_q),
    .result     (aluResult),
    .zero       (aluZero)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      lastGrant_q  <= 1'b1;
      opA_q        <= '0;
      opB_q        <= '0;
      opCode_q     <= '0;
      opId_q       <= 1'b0;
      respValid_q  <= 1'b0;
      respId_q     <= 1'b0;
      respResult_q <= '0;
      respZero_q   <= 1'b0;
      respErr_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (handshake) begin
            opA_q       <= grant1 ? req1_a  : req0_a;
            opB_q       <= grant1 ? req1_b  : req0_b;
            opCode_q    <= grant1 ? req1_op : req0_op;
            opId_q      <= grant1;
            lastGrant_q <= grant1;
            state_q     <= EXEC;
          end
        end
        EXEC: begin
          // Illegal codes still produce a response, just with the error flag and a cleared result.
          respValid_q  <= 1'b1;
          respId_q     <= opId_q;
          respErr_q    <= !opLegal;
          respResult_q <= opLegal ? aluResult : '0;
          respZero_q   <= opLegal && aluZero;
          state_q      <= DONE;
        end
        DONE: begin
          if (resp_ready) begin
            respValid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid  = respValid_q;
  assign resp_id     = respId_q;
  assign resp_result = respResult_q;
  assign resp_zero   = respZero_q;
  assign resp_err    = respErr_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus random traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_alu_arbiter;

  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]   req0_op, req1_op;
  logic         resp_valid, resp_ready, resp_id, resp_zero, resp_err;
  logic [N-1:0] resp_result;

  int total = 0;
  int bad   = 0;

  // Stimulus for the next cycle
  logic         stimRst, stimV0, stimV1, stimRr;
  logic [3:0]   stimOp0, stimOp1;
  logic [N-1:0] stimA0, stimB0, stimA1, stimB1;

  // Reference model: phase 0 accepting, 1 computing, 2 holding a response
  int           phase;
  int           lastWin;
  int           expId;
  logic [N-1:0] expRes;
  logic         expZero, expErr;
  bit           justReset;

  // Values seen on the response port, used by the directed scenarios
  bit           seenNow;
  logic [N-1:0] seenRes;
  logic         seenZero, seenErr, seenId;
  logic [N-1:0] tieRes1;
  int           grantLog[$];

  always #5 clk = ~clk;

  alu_arbiter #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req1_valid  (req1_valid),
    .req0_ready  (req0_ready),
    .req1_ready  (req1_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req0_op     (req0_op),
    .req1_op     (req1_op),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_zero   (resp_zero),
    .resp_err    (resp_err)
  );

  task automatic checkOutput(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Returns {err, result} straight from the opcode table
  function automatic logic [N:0] refAlu(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] r;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = a + b;
      4'd6: r = a - b;
      4'd7: r = b;
      default: return {1'b1, {N{1'b0}}};
    endcase
    return {1'b0, r};
  endfunction

  task automatic applyStimulus();
    logic       exp0, exp1;
    logic [N:0] r;
    @(negedge clk);
    reset = stimRst; req0_valid = stimV0; req1_valid = stimV1; resp_ready = stimRr;
    req0_op = stimOp0; req0_a = stimA0; req0_b = stimB0;
    req1_op = stimOp1; req1_a = stimA1; req1_b = stimB1;
    #1;
    exp0 = 1'b0;
    exp1 = 1'b0;
    if (stimRst && phase == 0) begin
      if (stimV0 && (!stimV1 || lastWin == 1)) exp0 = 1'b1;
      else if (stimV1) exp1 = 1'b1;
    end
    checkOutput("req0_ready", N'(req0_ready), N'(exp0));
    checkOutput("req1_ready", N'(req1_ready), N'(exp1));
    checkOutput("resp_valid", N'(resp_valid), N'(phase == 2));
    seenNow = (phase == 2);
    if (phase == 2) begin
      checkOutput("resp_id", N'(resp_id), N'(expId));
      checkOutput("resp_result", resp_result, expRes);
      checkOutput("resp_zero", N'(resp_zero), N'(expZero));
      checkOutput("resp_err", N'(resp_err), N'(expErr));
      seenRes = resp_result; seenZero = resp_zero; seenErr = resp_err; seenId = resp_id;
    end
    if (justReset) begin
      checkOutput("rst_id", N'(resp_id), '0);
      checkOutput("rst_result", resp_result, '0);
      checkOutput("rst_zero", N'(resp_zero), '0);
      checkOutput("rst_err", N'(resp_err), '0);
    end
    if (req0_ready && req0_valid) grantLog.push_back(0);
    if (req1_ready && req1_valid) grantLog.push_back(1);
    justReset = 1'b0;
    if (!stimRst) begin
      phase = 0; lastWin = 1; justReset = 1'b1;
    end else begin
      case (phase)
        0: if (exp0 || exp1) begin
          expId   = exp1 ? 1 : 0;
          r       = exp1 ? refAlu(stimOp1, stimA1, stimB1) : refAlu(stimOp0, stimA0, stimB0);
          expErr  = r[N];
          expRes  = r[N-1:0];
          expZero = !expErr && (expRes == '0);
          lastWin = expId;
          phase   = 1;
        end
        1: phase = 2;
        default: if (stimRr) phase = 0;
      endcase
    end
  endtask

  task automatic issueReq0(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    stimV0 = 1'b1; stimOp0 = op; stimA0 = a; stimB0 = b;
    applyStimulus();
    stimV0 = 1'b0;
    applyStimulus();
    applyStimulus();
  endtask

  initial begin
    logic [3:0] legalOps [5];
    legalOps = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7};
    phase = 0; lastWin = 1; justReset = 1'b0; expId = 0;
    expRes = '0; expZero = 1'b0; expErr = 1'b0;
    seenNow = 1'b0; seenRes = '0; seenZero = 1'b0; seenErr = 1'b0; seenId = 1'b0; tieRes1 = '0;
    stimRst = 1'b0; stimV0 = 1'b0; stimV1 = 1'b0; stimRr = 1'b1;
    stimOp0 = '0; stimOp1 = '0; stimA0 = '0; stimB0 = '0; stimA1 = '0; stimB1 = '0;

    // Reset, then one idle cycle checking reset values
    applyStimulus();
    applyStimulus();
    stimRst = 1'b1;
    applyStimulus();

    // Single ADD from req0
    issueReq0(4'b0010, 64'd93846573825364758, 64'd27313240968594);
    checkOutput("single_result", seenRes, 64'd93873887066333352);
    checkOutput("single_id", N'(seenId), '0);
    checkOutput("single_err", N'(seenErr), '0);
    applyStimulus();

    // Tie rotation right after reset
    stimRst = 1'b0; applyStimulus(); stimRst = 1'b1;
    grantLog.delete();
    stimV0 = 1'b1; stimV1 = 1'b1;
    stimOp0 = 4'b0010; stimA0 = 64'd5; stimB0 = 64'd7;
    stimOp1 = 4'b0110; stimA1 = 64'd27313240968594; stimB1 = 64'd93846573825364758;
    for (int i = 0; i < 12; i++) begin
      applyStimulus();
      if (seenNow && seenId) tieRes1 = seenRes;
    end
    checkOutput("tie_count", N'(grantLog.size()), N'(4));
    for (int i = 0; i < 4 && i < grantLog.size(); i++)
      checkOutput("tie_grant", N'(grantLog[i]), N'(i % 2));
    checkOutput("tie_sub_result", tieRes1, 64'd18352924813125155452);
    stimV0 = 1'b0; stimV1 = 1'b0;
    applyStimulus();

    // Zero flag and wrap-around
    issueReq0(4'b0110, 64'd27586970463758451, 64'd27586970463758451);
    checkOutput("sub_zero_result", seenRes, '0);
    checkOutput("sub_zero_flag", N'(seenZero), N'(1));
    issueReq0(4'b0010, 64'd9223372036854775807, 64'd2);
    checkOutput("add_wrap_result", seenRes, 64'd9223372036854775809);
    checkOutput("add_wrap_zero", N'(seenZero), '0);

    // Backpressure while both requesters keep asking
    stimV0 = 1'b1; stimV1 = 1'b1; stimOp0 = 4'b0001; stimOp1 = 4'b0000;
    stimA0 = {$urandom, $urandom}; stimB0 = {$urandom, $urandom};
    applyStimulus();
    applyStimulus();
    stimRr = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus();
    stimRr = 1'b1;
    applyStimulus();
    applyStimulus();
    stimV0 = 1'b0; stimV1 = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus();

    // Illegal opcode
    issueReq0(4'b1111, 64'd12345, 64'd678);
    checkOutput("illegal_err", N'(seenErr), N'(1));
    checkOutput("illegal_result", seenRes, '0);
    checkOutput("illegal_zero", N'(seenZero), '0);

    // Reset while holding a response, then a tie must go to req0
    stimV0 = 1'b1; stimOp0 = 4'b0010;
    applyStimulus();
    stimV0 = 1'b0;
    applyStimulus();
    stimRst = 1'b0;
    applyStimulus();
    stimRst = 1'b1;
    applyStimulus();
    grantLog.delete();
    stimV0 = 1'b1; stimV1 = 1'b1;
    applyStimulus();
    checkOutput("post_reset_count", N'(grantLog.size()), N'(1));
    if (grantLog.size() > 0) checkOutput("post_reset_grant", N'(grantLog[0]), '0);
    stimV0 = 1'b0; stimV1 = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      stimRst = ($urandom_range(0, 49) != 0);
      stimV0  = $urandom_range(0, 1) == 1;
      stimV1  = $urandom_range(0, 1) == 1;
      stimRr  = ($urandom_range(0, 3) != 0);
      stimOp0 = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : legalOps[$urandom_range(0, 4)];
      stimOp1 = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : legalOps[$urandom_range(0, 4)];
      stimA0  = {$urandom, $urandom}; stimB0 = {$urandom, $urandom};
      stimA1  = {$urandom, $urandom}; stimB1 = ($urandom_range(0, 7) == 0) ? stimA1 : {$urandom, $urandom};
      applyStimulus();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
